// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared types and constants for the ADC-stream UART frame receiver.
//   parse_state_e : frame parser states (HUNT, MSB, LSB)
//   rx_state_e    : bit receiver states (IDLE, START, DATA, STOP, BREAK)
//   SYNC_BYTE_DEF : default frame start marker
package uart_frame_pkg;

   typedef enum logic [1:0] {
      HUNT,
      MSB,
      LSB
   } parse_state_e;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_e;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;

endpackage : uart_frame_pkg

// File: rtl/uart_rx.sv
// uart_rx: 2-FF synchronizer plus 8N1 LSB-first bit receiver.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   rx         : asynchronous UART line, idles high
//   data[7:0]  : last received byte, valid while/after the valid pulse
//   valid      : one-cycle pulse on a good stop bit
//   frame_err  : one-cycle pulse on a low stop bit
module uart_rx
   import uart_frame_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 12000000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);

   rx_state_e        state_q, state_d;
   logic             meta_q, meta_d;
   logic             sync_q, sync_d;
   logic             prev_q, prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;

   // State and data registers; synchronizer resets to the idle (high) level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         meta_q  <= 1'b1;
         sync_q  <= 1'b1;
         prev_q  <= 1'b1;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         meta_q  <= meta_d;
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   // Next-state logic for the bit receiver
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      meta_d  = rx;
      sync_d  = meta_q;
      prev_d  = sync_q;

      unique case (state_q)
         IDLE: begin
            if (prev_q && !sync_q) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            // Mid-start resample rejects glitches shorter than half a bit
            if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = sync_q ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
               cnt_d   = '0;
               shift_d = {sync_q, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            // Leaving at mid-stop keeps zero-gap back-to-back bytes aligned
            if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
               cnt_d = '0;
               if (sync_q) begin
                  valid_d = 1'b1;
                  data_d  = shift_q;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         BREAK: begin
            // Hold off until the line is released so a stuck-low line errs once
            if (sync_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;

endmodule : uart_rx

// File: rtl/uart_sample_rx.sv
// uart_sample_rx: receives {SYNC_BYTE, sample MSB, sample LSB} UART frames and
// reassembles the 16-bit sample.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   rx            : asynchronous UART line, idles high
//   sample[15:0]  : last complete sample {MSB, LSB}, held between frames
//   sample_valid  : one-cycle pulse when sample updates
//   frame_err     : one-cycle pulse on a stop-bit error
//   busy          : high while the parser is collecting MSB/LSB
// Build option: define FRAME_TIMEOUT_EN to drop partial frames after
// TIMEOUT_BITS bit periods without a byte.
module uart_sample_rx
   import uart_frame_pkg::*;
#(
   parameter int unsigned CLK_FREQ     = 12000000,
   parameter int unsigned BAUD         = 115200,
   parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF,
   parameter int unsigned TIMEOUT_BITS = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic [15:0] sample,
   output logic        sample_valid,
   output logic        frame_err,
   output logic        busy
);

   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_err;

   uart_rx #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) u_rx (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (byte_data),
      .valid     (byte_valid),
      .frame_err (byte_err)
   );

   parse_state_e state_q, state_d;
   logic [7:0]   msb_q, msb_d;
   logic [15:0]  sample_q, sample_d;
   logic         sample_valid_q, sample_valid_d;
   logic         frame_err_q, frame_err_d;
   logic         busy_q, busy_d;
   logic         tmo_hit_c;

`ifdef FRAME_TIMEOUT_EN
   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int unsigned TMO_LIMIT    = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned TMO_W        = $clog2(TMO_LIMIT + 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;

   assign tmo_hit_c = (tmo_q == TMO_W'(TMO_LIMIT));

   // Inter-byte timer: restarts on every byte, idles at zero in HUNT
   always_comb begin
      tmo_d = tmo_q;
      if (byte_valid || (state_q == HUNT)) begin
         tmo_d = '0;
      end else if (!tmo_hit_c) begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   logic unused_timeout_c;

   assign tmo_hit_c        = 1'b0;
   assign unused_timeout_c = (TIMEOUT_BITS != 0);
`endif

   // Parser state and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= HUNT;
         msb_q          <= '0;
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
         frame_err_q    <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         msb_q          <= msb_d;
         sample_q       <= sample_d;
         sample_valid_q <= sample_valid_d;
         frame_err_q    <= frame_err_d;
         busy_q         <= busy_d;
      end
   end

   // Frame parser; a byte error or timeout always restarts the hunt
   always_comb begin
      state_d        = state_q;
      msb_d          = msb_q;
      sample_d       = sample_q;
      sample_valid_d = 1'b0;
      frame_err_d    = byte_err;

      if (byte_err) begin
         state_d = HUNT;
      end else if (byte_valid) begin
         unique case (state_q)
            HUNT: begin
               if (byte_data == SYNC_BYTE) begin
                  state_d = MSB;
               end
            end
            MSB: begin
               msb_d   = byte_data;
               state_d = LSB;
            end
            LSB: begin
               sample_d       = {msb_q, byte_data};
               sample_valid_d = 1'b1;
               state_d        = HUNT;
            end
            default: state_d = HUNT;
         endcase
      end else if (tmo_hit_c) begin
         state_d = HUNT;
      end

      busy_d = (state_d != HUNT);
   end

   assign sample       = sample_q;
   assign sample_valid = sample_valid_q;
   assign frame_err    = frame_err_q;
   assign busy         = busy_q;

endmodule : uart_sample_rx

// File: tb/tb_uart_sample_rx.sv
// tb_uart_sample_rx: scoreboard bench for uart_sample_rx at default parameters.
`timescale 1ns/1ps
module tb_uart_sample_rx;

   localparam int unsigned CPB = 12000000 / 115200;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx  = 1'b1;
   logic [15:0] sample;
   logic        sample_valid;
   logic        frame_err;
   logic        busy;

   int          tests_run    = 0;
   int          tests_failed = 0;
   int          err_seen     = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   uart_sample_rx dut (
      .clk          (clk),
      .rst          (rst),
      .rx           (rx),
      .sample       (sample),
      .sample_valid (sample_valid),
      .frame_err    (frame_err),
      .busy         (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every sample strobe must match the oldest expected sample
   always @(negedge clk) begin
      if (!rst) begin
         if (sample_valid) begin
            logic [31:0] e;
            e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
            check("sample", 32'(sample), e);
         end
         if (frame_err) err_seen++;
      end
   end

   task automatic bits(input int n);
      repeat (n * CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
      rx = 1'b0;
      bits(1);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         bits(1);
      end
      rx = stop_bit;
      bits(1);
      rx = 1'b1;
   endtask

   // Let the last strobe land, then the queue must be drained
   task automatic drain(input string tag, input int exp_err);
      bits(3);
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_frame_err_cnt"}, 32'(err_seen), 32'(exp_err));
      check({tag, "_busy_idle"}, 32'(busy), 32'd0);
      err_seen = 0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (5) @(negedge clk);
      check("rst_sample", 32'(sample), 32'd0);
      check("rst_valid", 32'(sample_valid), 32'd0);
      check("rst_err", 32'(frame_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      bits(2);

      // Basic frame
      exp_q.push_back(16'h1234);
      send_byte(8'hAA);
      check("t1_busy_after_sync", 32'(busy), 32'd1);
      send_byte(8'h12);
      send_byte(8'h34);
      drain("t1", 0);

      // Leading junk dropped
      exp_q.push_back(16'h0FFF);
      send_byte(8'h55);
      send_byte(8'h07);
      check("t2_busy_hunting", 32'(busy), 32'd0);
      send_byte(8'hAA);
      send_byte(8'h0F);
      send_byte(8'hFF);
      drain("t2", 0);

      // Sync value as payload, zero-gap back-to-back frames
      exp_q.push_back(16'hAAAA);
      exp_q.push_back(16'h0001);
      send_byte(8'hAA);
      send_byte(8'hAA);
      send_byte(8'hAA);
      send_byte(8'hAA);
      send_byte(8'h00);
      send_byte(8'h01);
      drain("t3", 0);
      check("t3_sample_hold", 32'(sample), 32'h0001);

      // Bad stop bit aborts the frame
      send_byte(8'hAA);
      send_byte(8'h12, 1'b0);
      bits(2);
      exp_q.push_back(16'h5678);
      send_byte(8'hAA);
      send_byte(8'h56);
      send_byte(8'h78);
      drain("t4", 1);

      // Line held low: a single error, then recovery
      rx = 1'b0;
      bits(40);
      rx = 1'b1;
      bits(2);
      exp_q.push_back(16'hBEEF);
      send_byte(8'hAA);
      send_byte(8'hBE);
      send_byte(8'hEF);
      drain("t5", 1);

`ifdef FRAME_TIMEOUT_EN
      // Stalled frame is dropped silently after the timeout
      exp_q.push_back(16'h9ABC);
      send_byte(8'hAA);
      send_byte(8'h12);
      bits(31);
      check("t6_busy_timed_out", 32'(busy), 32'd0);
      send_byte(8'h34);
      send_byte(8'hAA);
      send_byte(8'h9A);
      send_byte(8'hBC);
      drain("t6", 0);
`endif

      // Reset in the middle of the MSB byte
      send_byte(8'hAA);
      rx = 1'b0;
      bits(1);
      rx = 1'b1;
      bits(2);
      check("t7_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("t7_rst_sample", 32'(sample), 32'd0);
      check("t7_rst_valid", 32'(sample_valid), 32'd0);
      check("t7_rst_err", 32'(frame_err), 32'd0);
      check("t7_rst_busy", 32'(busy), 32'd0);
      bits(1);
      rst = 1'b0;
      bits(2);
      exp_q.push_back(16'h1357);
      send_byte(8'hAA);
      send_byte(8'h13);
      send_byte(8'h57);
      drain("t7", 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_uart_sample_rx
